// File: rtl/clock_gen.sv
// Two-phase CPU bus clock generator: phi_0 is a registered divide-by-DIV clock
// with programmable high time, phi_2 is phi_0 delayed by PHI2_DELAY system clocks.
module clock_gen #(
  parameter int unsigned DIV         = 100,
  parameter int unsigned HIGH_CYCLES = 50,
  parameter int unsigned PHI2_DELAY  = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic phi_0,
  output logic phi_2
);

  localparam int unsigned LOW_CYCLES = DIV - HIGH_CYCLES;
  localparam int unsigned CNT_W      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned MIN_PHASE  = (HIGH_CYCLES < LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("clock_gen: DIV must be at least 2");
    end
    if ((HIGH_CYCLES < 1) || (HIGH_CYCLES + 1 > DIV)) begin : g_bad_high
      $error("clock_gen: HIGH_CYCLES must lie in 1..DIV-1");
    end
    if (PHI2_DELAY >= MIN_PHASE) begin : g_bad_delay
      $error("clock_gen: PHI2_DELAY must be below both HIGH_CYCLES and DIV-HIGH_CYCLES");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             phi0_q;
  logic             phi0_d;

  // phi0 is decoded from the next count so the flop tracks cnt on the same edge.
  always_comb begin
    cnt_d  = (cnt_q == CNT_W'(DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
    phi0_d = (cnt_d >= CNT_W'(LOW_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      phi0_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      phi0_q <= phi0_d;
    end
  end

  assign phi_0 = phi0_q;

  generate
    if (PHI2_DELAY == 0) begin : g_no_delay
      assign phi_2 = phi0_q;
    end else begin : g_delay
      logic [PHI2_DELAY-1:0] dly_q;
      logic [PHI2_DELAY-1:0] dly_d;

      always_comb begin
        dly_d = (dly_q << 1) | PHI2_DELAY'(phi0_q);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_q <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign phi_2 = dly_q[PHI2_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen: three parameter variants sharing one clock and reset,
// checked per edge against an arithmetic model plus fixed edge tables.
`timescale 1ns/100ps
module tb_clock_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a_phi0, a_phi2, b_phi0, b_phi2, c_phi0, c_phi2;

  always #5 clk = ~clk;

  clock_gen #(.DIV(100), .HIGH_CYCLES(50), .PHI2_DELAY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .phi_0(a_phi0), .phi_2(a_phi2));
  clock_gen #(.DIV(4), .HIGH_CYCLES(2), .PHI2_DELAY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .phi_0(b_phi0), .phi_2(b_phi2));
  clock_gen #(.DIV(7), .HIGH_CYCLES(3), .PHI2_DELAY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .phi_0(c_phi0), .phi_2(c_phi2));

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned n        = 0;

  typedef struct {
    string       name;
    bit          sel_b;
    int unsigned edge_n;
    bit          phi0;
    bit          phi2;
  } vec_t;
  vec_t tbl[$];

  // phi_0 after edge e is high for the last HIGH clocks of each DIV-clock period.
  function automatic bit ref_phi0(int unsigned e, int unsigned div, int unsigned high);
    return (e % div) >= (div - high);
  endfunction

  function automatic bit ref_phi2(int unsigned e, int unsigned div, int unsigned high,
                                  int unsigned dly);
    if (e < dly) return 1'b0;
    return ref_phi0(e - dly, div, high);
  endfunction

  task automatic check(input string name, input bit act, input bit exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0b expected=%0b", name, n, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_phi0"}, a_phi0, 1'b0);
    check({tag, "_a_phi2"}, a_phi2, 1'b0);
    check({tag, "_b_phi0"}, b_phi0, 1'b0);
    check({tag, "_b_phi2"}, b_phi2, 1'b0);
    check({tag, "_c_phi0"}, c_phi0, 1'b0);
    check({tag, "_c_phi2"}, c_phi2, 1'b0);
  endtask

  task automatic check_model();
    check("model_a_phi0", a_phi0, ref_phi0(n, 100, 50));
    check("model_a_phi2", a_phi2, ref_phi2(n, 100, 50, 2));
    check("model_b_phi0", b_phi0, ref_phi0(n, 4, 2));
    check("model_b_phi2", b_phi2, ref_phi2(n, 4, 2, 1));
    check("model_c_phi0", c_phi0, ref_phi0(n, 7, 3));
    check("model_c_phi2_eq", c_phi2, c_phi0);
  endtask

  task automatic check_table();
    foreach (tbl[i]) begin
      if (tbl[i].edge_n == n) begin
        check({tbl[i].name, "_phi0"}, tbl[i].sel_b ? b_phi0 : a_phi0, tbl[i].phi0);
        check({tbl[i].name, "_phi2"}, tbl[i].sel_b ? b_phi2 : a_phi2, tbl[i].phi2);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
  endtask

  // Drop reset between clock edges and confirm outputs clear with no edge.
  task automatic async_reset(input int unsigned offset_ns, input string tag);
    #(offset_ns);
    rst_n = 1'b0;
    #0.5;
    check_zero(tag);
  endtask

  int unsigned a_rise0, a_rise2;
  bit          prev0, prev2;
  int unsigned run_len, hold;

  initial begin
    tbl.push_back('{"dflt_e1",   1'b0, 1,   1'b0, 1'b0});
    tbl.push_back('{"dflt_e49",  1'b0, 49,  1'b0, 1'b0});
    tbl.push_back('{"dflt_e50",  1'b0, 50,  1'b1, 1'b0});
    tbl.push_back('{"dflt_e51",  1'b0, 51,  1'b1, 1'b0});
    tbl.push_back('{"dflt_e52",  1'b0, 52,  1'b1, 1'b1});
    tbl.push_back('{"dflt_e99",  1'b0, 99,  1'b1, 1'b1});
    tbl.push_back('{"dflt_e100", 1'b0, 100, 1'b0, 1'b1});
    tbl.push_back('{"dflt_e101", 1'b0, 101, 1'b0, 1'b1});
    tbl.push_back('{"dflt_e102", 1'b0, 102, 1'b0, 1'b0});
    tbl.push_back('{"dflt_e150", 1'b0, 150, 1'b1, 1'b0});
    tbl.push_back('{"dflt_e152", 1'b0, 152, 1'b1, 1'b1});
    tbl.push_back('{"div4_e0",   1'b1, 0,   1'b0, 1'b0});
    tbl.push_back('{"div4_e1",   1'b1, 1,   1'b0, 1'b0});
    tbl.push_back('{"div4_e2",   1'b1, 2,   1'b1, 1'b0});
    tbl.push_back('{"div4_e3",   1'b1, 3,   1'b1, 1'b1});
    tbl.push_back('{"div4_e4",   1'b1, 4,   1'b0, 1'b1});
    tbl.push_back('{"div4_e5",   1'b1, 5,   1'b0, 1'b0});
    tbl.push_back('{"div4_e6",   1'b1, 6,   1'b1, 1'b0});
    tbl.push_back('{"div4_e7",   1'b1, 7,   1'b1, 1'b1});
    tbl.push_back('{"div4_e8",   1'b1, 8,   1'b0, 1'b1});

    // Reset hold with the clock running.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end

    // Release at t=100 ns and run 500 edges (5 us).
    wait ($time >= 100);
    rst_n = 1'b1;
    n = 0;
    #0.5;
    check_table();
    a_rise0 = 0;
    a_rise2 = 0;
    prev0   = a_phi0;
    prev2   = a_phi2;
    for (int i = 0; i < 500; i++) begin
      step();
      check_model();
      check_table();
      if (a_phi0 && !prev0) a_rise0++;
      if (a_phi2 && !prev2) a_rise2++;
      prev0 = a_phi0;
      prev2 = a_phi2;
    end
    checks++;
    if (a_rise0 != 5) begin
      failures++;
      $display("FAIL phi0_rise_count got=%0d expected=5", a_rise0);
    end
    checks++;
    if (a_rise2 != 5) begin
      failures++;
      $display("FAIL phi2_rise_count got=%0d expected=5", a_rise2);
    end

    // Continue to cnt=70 of the default variant, then reset mid-high phase.
    while (n < 570) begin
      step();
      check_model();
    end
    check("mid_a_phi0_high", a_phi0, 1'b1);
    async_reset(3, "mid_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("mid_hold");
    end
    release_reset();
    for (int i = 0; i < 160; i++) begin
      step();
      check_model();
      check_table();
    end

    // Random run lengths and random asynchronous reset points.
    for (int it = 0; it < 8; it++) begin
      run_len = $urandom_range(1, 300);
      for (int unsigned k = 0; k < run_len; k++) begin
        step();
        check_model();
      end
      async_reset($urandom_range(1, 8), "rand_rst");
      hold = $urandom_range(0, 3);
      for (int unsigned k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        check_zero("rand_hold");
      end
      release_reset();
    end
    for (int i = 0; i < 60; i++) begin
      step();
      check_model();
      check_table();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
